// File: rtl/lynx_kbd_pkg.sv
// Shared definitions for the Lynx keyboard matrix helpers.
// Contents: matrix geometry, bit positions of a queued key entry, sequencer state encoding.
package lynx_kbd_pkg;

   localparam int unsigned KBD_ROWS  = 10;
   localparam int unsigned SHIFT_ROW = 0;
   localparam int unsigned SHIFT_BIT = 7;

   // Queued entry layout: [8]=shift, [7:4]=row, [3]=reserved, [2:0]=column bit
   localparam int unsigned ENTRY_W    = 9;
   localparam int unsigned ENT_SHIFT  = 8;
   localparam int unsigned ENT_ROW_HI = 7;
   localparam int unsigned ENT_ROW_LO = 4;
   localparam int unsigned ENT_RSVD   = 3;
   localparam int unsigned ENT_COL_HI = 2;
   localparam int unsigned ENT_COL_LO = 0;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StPress,
      StRelease
   } state_t;

endpackage

// File: rtl/key_inject_if.sv
// Host-side bus of the key injector.
// Signals: wr/wr_data push an entry, abort flushes, row selects the scanned row,
// mask_out is the active-low override for that row, full/busy/err report status.
// Modports: master = host/top level, slave = key_inject.
interface key_inject_if;
   import lynx_kbd_pkg::*;

   logic               wr;
   logic [ENTRY_W-1:0] wr_data;
   logic               abort;
   logic [3:0]         row;
   logic [7:0]         mask_out;
   logic               full;
   logic               busy;
   logic               err;

   modport master (
      output wr, wr_data, abort, row,
      input  mask_out, full, busy, err
   );

   modport slave (
      input  wr, wr_data, abort, row,
      output mask_out, full, busy, err
   );

endinterface

// File: rtl/key_inject_fifo.sv
// Synchronous DEPTH x WIDTH circular FIFO with flush.
// Ports: clock, reset (sync, active high), flush (empties), push/din, pop/dout (head,
// valid while !empty), count (entries held), full, empty.
// Push is judged on the registered count, so a push while full is dropped even if a
// pop happens in the same cycle.
module key_inject_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 9
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp_q, rp_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp_q];
   assign count   = cnt_q;

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + AW'(1);
         if (do_pop)  rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wp_q] <= din;
   end

endmodule

// File: rtl/key_inject.sv
// Automatic key-typing sequencer for the Lynx keyboard matrix. Queued entries are
// replayed as timed shift-settle / press / release sequences; the result is an
// active-low mask for the currently scanned row, ANDed with the matrix data upstream.
// Ports: clock, reset (sync, active high), ce (tick enable for all timers),
// bus (slave modport: wr, wr_data, abort, row, mask_out, full, busy, err).
module key_inject
   import lynx_kbd_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned HOLD   = 20000,
   parameter int unsigned GAP    = 20000,
   parameter int unsigned SETTLE = 2000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   key_inject_if.slave bus
);

   localparam int unsigned TMAX0 = (HOLD > GAP) ? HOLD : GAP;
   localparam int unsigned TMAX  = (TMAX0 > SETTLE) ? TMAX0 : SETTLE;
   localparam int unsigned CW    = (TMAX > 1) ? $clog2(TMAX) : 1;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 act_shift_q;
   logic [3:0]           act_row_q;
   logic [2:0]           act_col_q;
   logic                 load;
   logic [ENTRY_W-1:0]   head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                 fifo_full, fifo_empty;
   logic                 unused_rsvd;
   logic [7:0]           mask;

   assign unused_rsvd = head[ENT_RSVD];

   key_inject_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (bus.abort),
      .push  (bus.wr && !bus.abort),
      .din   (bus.wr_data),
      .pop   (load),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               load    = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            cnt_d = '0;
            if (act_row_q >= 4'(KBD_ROWS)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = act_shift_q ? StShift : StPress;
            end
         end
         StShift: begin
            if (ce) begin
               if (cnt_q == CW'(SETTLE - 1)) begin
                  cnt_d   = '0;
                  state_d = StPress;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StPress: begin
            if (ce) begin
               if (cnt_q == CW'(HOLD - 1)) begin
                  cnt_d   = '0;
                  state_d = StRelease;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StRelease: begin
            if (ce) begin
               if (cnt_q == CW'(GAP - 1)) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Abort overrides everything except reset; err is deliberately kept.
      if (bus.abort) begin
         state_d = StIdle;
         cnt_d   = '0;
         load    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         act_shift_q <= 1'b0;
         act_row_q   <= '0;
         act_col_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (load) begin
            act_shift_q <= head[ENT_SHIFT];
            act_row_q   <= head[ENT_ROW_HI:ENT_ROW_LO];
            act_col_q   <= head[ENT_COL_HI:ENT_COL_LO];
         end
      end
   end

   // Zero-latency to row: the CPU scan may change row on any cycle.
   always_comb begin
      mask = 8'hFF;
      if (state_q == StPress && bus.row == act_row_q) mask[act_col_q] = 1'b0;
      if ((state_q == StShift || state_q == StPress) && act_shift_q &&
          bus.row == 4'(SHIFT_ROW)) begin
         mask[SHIFT_BIT] = 1'b0;
      end
   end

   assign bus.mask_out = mask;
   assign bus.full     = fifo_full;
   assign bus.busy     = (fifo_count != '0) || (state_q != StIdle);
   assign bus.err      = err_q;

endmodule

// File: tb/tb_key_inject.sv
// Directed self-checking bench for key_inject (DEPTH=4, HOLD=4, GAP=3, SETTLE=2).
module tb_key_inject;

   logic clock;
   logic reset;
   logic ce;
   int   n_vec;
   int   n_err;

   key_inject_if bus ();

   key_inject #(
      .DEPTH  (4),
      .HOLD   (4),
      .GAP    (3),
      .SETTLE (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .ce    (ce),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [8:0] full_ents [4];
   logic [3:0] full_rows [4];
   logic [7:0] full_masks [4];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      bus.row = 4'd0;
      #1;
      n_vec++; if (bus.mask_out !== 8'hFF) begin n_err++;
         $display("FAIL reset_mask: got %h expected ff", bus.mask_out); end
      n_vec++; if (bus.full !== 1'b0) begin n_err++;
         $display("FAIL reset_full: got %b expected 0", bus.full); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++;
         $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_vec++; if (bus.err !== 1'b0) begin n_err++;
         $display("FAIL reset_err: got %b expected 0", bus.err); end
   endtask

   task automatic test_unshifted();
      logic [7:0] exp_m;
      bus.wr      = 1'b1;
      bus.wr_data = 9'h024;
      for (int k = 0; k < 10; k++) begin
         tick();
         bus.wr  = 1'b0;
         bus.row = 4'd2;
         #1;
         exp_m = (k >= 2 && k <= 5) ? 8'hEF : 8'hFF;
         n_vec++; if (bus.mask_out !== exp_m) begin n_err++;
            $display("FAIL unshift_row2 k=%0d: got %h expected %h", k, bus.mask_out, exp_m); end
         bus.row = 4'd5;
         #1;
         n_vec++; if (bus.mask_out !== 8'hFF) begin n_err++;
            $display("FAIL unshift_row5 k=%0d: got %h expected ff", k, bus.mask_out); end
         n_vec++; if (bus.busy !== (k < 9)) begin n_err++;
            $display("FAIL unshift_busy k=%0d: got %b expected %b", k, bus.busy, k < 9); end
      end
   endtask

   task automatic test_shifted();
      logic [7:0] exp0, exp1;
      bus.wr      = 1'b1;
      bus.wr_data = 9'h115;
      for (int k = 0; k < 12; k++) begin
         tick();
         bus.wr  = 1'b0;
         bus.row = 4'd0;
         #1;
         exp0 = (k >= 2 && k <= 7) ? 8'h7F : 8'hFF;
         exp1 = (k >= 4 && k <= 7) ? 8'hDF : 8'hFF;
         n_vec++; if (bus.mask_out !== exp0) begin n_err++;
            $display("FAIL shift_row0 k=%0d: got %h expected %h", k, bus.mask_out, exp0); end
         bus.row = 4'd1;
         #1;
         n_vec++; if (bus.mask_out !== exp1) begin n_err++;
            $display("FAIL shift_row1 k=%0d: got %h expected %h", k, bus.mask_out, exp1); end
         n_vec++; if (bus.busy !== (k < 11)) begin n_err++;
            $display("FAIL shift_busy k=%0d: got %b expected %b", k, bus.busy, k < 11); end
      end
   endtask

   task automatic test_fifo_full();
      logic found;
      logic seen;
      // A first key parks the FSM in PRESS while ce is held low.
      bus.wr      = 1'b1;
      bus.wr_data = 9'h060;
      tick();
      bus.wr = 1'b0;
      tick();
      tick();
      bus.row = 4'd6;
      #1;
      n_vec++; if (bus.mask_out !== 8'hFE) begin n_err++;
         $display("FAIL full_hold_key: got %h expected fe", bus.mask_out); end
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.wr      = 1'b1;
         bus.wr_data = (i < 4) ? full_ents[i] : 9'h055;
         tick();
         n_vec++; if (bus.full !== (i >= 3)) begin n_err++;
            $display("FAIL full_flag push=%0d: got %b expected %b", i, bus.full, i >= 3); end
      end
      bus.wr = 1'b0;
      ce     = 1'b1;
      for (int j = 0; j < 4; j++) begin
         found = 1'b0;
         for (int c = 0; c < 30 && !found; c++) begin
            tick();
            bus.row = full_rows[j];
            #1;
            if (bus.mask_out !== 8'hFF) found = 1'b1;
         end
         n_vec++;
         if (!found) begin n_err++;
            $display("FAIL full_replay_%0d: got no press expected %h", j, full_masks[j]);
         end else if (bus.mask_out !== full_masks[j]) begin n_err++;
            $display("FAIL full_replay_%0d: got %h expected %h", j, bus.mask_out, full_masks[j]);
         end
      end
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         bus.row = 4'd5;
         #1;
         if (bus.mask_out !== 8'hFF) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++;
         $display("FAIL full_dropped: got press=%b expected 0", seen); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++;
         $display("FAIL full_done_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_invalid_row();
      logic found;
      bus.wr      = 1'b1;
      bus.wr_data = 9'h0A0;
      tick();
      bus.wr_data = 9'h030;
      tick();
      bus.wr  = 1'b0;
      bus.row = 4'd10;
      #1;
      n_vec++; if (bus.err !== 1'b0) begin n_err++;
         $display("FAIL inv_err_early: got %b expected 0", bus.err); end
      n_vec++; if (bus.mask_out !== 8'hFF) begin n_err++;
         $display("FAIL inv_row10_a: got %h expected ff", bus.mask_out); end
      tick();
      n_vec++; if (bus.err !== 1'b1) begin n_err++;
         $display("FAIL inv_err_set: got %b expected 1", bus.err); end
      n_vec++; if (bus.mask_out !== 8'hFF) begin n_err++;
         $display("FAIL inv_row10_b: got %h expected ff", bus.mask_out); end
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         tick();
         bus.row = 4'd3;
         #1;
         if (bus.mask_out !== 8'hFF) found = 1'b1;
      end
      n_vec++;
      if (!found) begin n_err++;
         $display("FAIL inv_next_press: got no press expected fe");
      end else if (bus.mask_out !== 8'hFE) begin n_err++;
         $display("FAIL inv_next_press: got %h expected fe", bus.mask_out);
      end
      for (int c = 0; c < 30 && bus.busy; c++) tick();
      n_vec++; if (bus.busy !== 1'b0) begin n_err++;
         $display("FAIL inv_idle: got %b expected 0", bus.busy); end
      n_vec++; if (bus.err !== 1'b1) begin n_err++;
         $display("FAIL inv_err_sticky: got %b expected 1", bus.err); end
   endtask

   task automatic test_abort();
      logic any_busy;
      logic any_press;
      bus.wr      = 1'b1;
      bus.wr_data = 9'h071;
      tick();
      bus.wr_data = 9'h082;
      tick();
      bus.wr_data = 9'h093;
      tick();
      bus.wr = 1'b0;
      tick();
      bus.row = 4'd7;
      #1;
      n_vec++; if (bus.mask_out !== 8'hFD) begin n_err++;
         $display("FAIL abort_pre_press: got %h expected fd", bus.mask_out); end
      bus.abort   = 1'b1;
      bus.wr      = 1'b1;
      bus.wr_data = 9'h014;
      tick();
      bus.abort = 1'b0;
      bus.wr    = 1'b0;
      bus.row   = 4'd7;
      #1;
      n_vec++; if (bus.mask_out !== 8'hFF) begin n_err++;
         $display("FAIL abort_mask: got %h expected ff", bus.mask_out); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++;
         $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      any_busy  = 1'b0;
      any_press = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.busy) any_busy = 1'b1;
         bus.row = 4'd1;
         #1;
         if (bus.mask_out !== 8'hFF) any_press = 1'b1;
         bus.row = 4'd8;
         #1;
         if (bus.mask_out !== 8'hFF) any_press = 1'b1;
      end
      n_vec++; if (any_busy !== 1'b0) begin n_err++;
         $display("FAIL abort_stays_idle: got busy=%b expected 0", any_busy); end
      n_vec++; if (any_press !== 1'b0) begin n_err++;
         $display("FAIL abort_no_press: got press=%b expected 0", any_press); end
   endtask

   task automatic test_reset_mid_shift();
      logic any_busy;
      logic any_press;
      bus.wr      = 1'b1;
      bus.wr_data = 9'h100;
      tick();
      bus.wr_data = 9'h022;
      tick();
      bus.wr = 1'b0;
      tick();
      bus.row = 4'd0;
      #1;
      n_vec++; if (bus.mask_out !== 8'h7F) begin n_err++;
         $display("FAIL rst_mid_shift_pre: got %h expected 7f", bus.mask_out); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_vec++; if (bus.mask_out !== 8'hFF) begin n_err++;
         $display("FAIL rst_mid_mask: got %h expected ff", bus.mask_out); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++;
         $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
      n_vec++; if (bus.err !== 1'b0) begin n_err++;
         $display("FAIL rst_mid_err: got %b expected 0", bus.err); end
      any_busy  = 1'b0;
      any_press = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (bus.busy) any_busy = 1'b1;
         bus.row = 4'd2;
         #1;
         if (bus.mask_out !== 8'hFF) any_press = 1'b1;
      end
      n_vec++; if (any_busy !== 1'b0 || any_press !== 1'b0) begin n_err++;
         $display("FAIL rst_mid_queue_empty: got busy=%b press=%b expected 0 0",
                  any_busy, any_press); end
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      reset       = 1'b1;
      ce          = 1'b1;
      bus.wr      = 1'b0;
      bus.wr_data = '0;
      bus.abort   = 1'b0;
      bus.row     = 4'd0;
      full_ents[0] = 9'h011; full_rows[0] = 4'd1; full_masks[0] = 8'hFD;
      full_ents[1] = 9'h022; full_rows[1] = 4'd2; full_masks[1] = 8'hFB;
      full_ents[2] = 9'h033; full_rows[2] = 4'd3; full_masks[2] = 8'hF7;
      full_ents[3] = 9'h044; full_rows[3] = 4'd4; full_masks[3] = 8'hEF;

      test_reset();
      test_unshifted();
      test_shifted();
      test_fifo_full();
      test_invalid_row();
      test_abort();
      test_reset_mid_shift();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
